// File: rtl/dmem_if_pkg.sv
// dmem_if_pkg: shared definitions for the data-memory bus interface.
// Holds the access-size encodings (also used by the MEM stage), the FSM state
// type and small helpers for size normalisation and alignment checking.
package dmem_if_pkg;

  // Access-size encodings; 2'b11 is treated as a word access.
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Fold the reserved encoding onto WORD so the rest of the logic sees three sizes.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SizeWord : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (norm_size(size))
      SizeByte: mis = 1'b0;
      SizeHalf: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_if_if.sv
// dmem_if_if: bundle of the MEM-stage request/response signals and the
// req/ack data bus.
//   master : view of dmem_if (takes MEM-stage requests, masters the bus)
//   slave  : view of the environment (MEM stage plus the memory/bus slave)
// MEM side : mreq, write, access_size, addr, wr_data -> rd_data, stall, misalign, bus_err
// Bus side : bus_req, bus_we, bus_addr, bus_be, bus_wdata -> bus_ack, bus_rdata
interface dmem_if_if;
  logic        mreq;
  logic        write;
  logic [1:0]  access_size;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        stall;
  logic        misalign;
  logic        bus_err;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  mreq, write, access_size, addr, wr_data, bus_ack, bus_rdata,
    output rd_data, stall, misalign, bus_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output mreq, write, access_size, addr, wr_data, bus_ack, bus_rdata,
    input  rd_data, stall, misalign, bus_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane formatter.
//   i_size, i_addr_lo : access size and byte offset within the word
//   i_wr_data         : LSB-aligned store data
//   i_bus_rdata       : raw bus read word
//   o_be              : byte-lane enables
//   o_wdata           : store data replicated across lanes
//   o_rd_data         : read data shifted down to bit 0 and masked by size
module dmem_lane
  import dmem_if_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rd_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_bus_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be      = 4'b1111;
    o_wdata   = i_wr_data;
    o_rd_data = w_shifted;
    case (i_size)
      SizeByte: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wr_data[7:0]}};
        o_rd_data = {24'h0, w_shifted[7:0]};
      end
      SizeHalf: begin
        o_be      = 4'b0011 << i_addr_lo;
        o_wdata   = {2{i_wr_data[15:0]}};
        o_rd_data = {16'h0, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_if.sv
// dmem_if: converts a single-cycle MEM-stage memory request into a word-aligned,
// byte-enabled req/ack bus transaction, stalling the pipeline until it completes.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : MEM-stage request/response and data-bus signals (master view)
// Misaligned requests are never issued; requests that see no ack within
// TIMEOUT_CYCLES REQ cycles are aborted and flagged with bus_err.
module dmem_if
  import dmem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  dmem_if_if.master   io_bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic              r_bus_req;
  logic [31:0]       r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;
  logic [31:0]       r_rd_data;
  logic              r_misalign;
  logic              r_bus_err;

  logic [1:0]        w_size;
  logic [1:0]        w_addr_lo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_misaligned;
  logic              w_cnt_last;

  // In IDLE the formatter sees the live request so be/wdata can be captured;
  // afterwards it sees the captured size/offset for read-data alignment.
  assign w_size    = (r_state == StIdle) ? norm_size(io_bus.access_size) : r_size;
  assign w_addr_lo = (r_state == StIdle) ? io_bus.addr[1:0] : r_addr_lo;

  assign w_misaligned = is_misaligned(io_bus.access_size, io_bus.addr[1:0]);
  // Counter holds the number of REQ cycles already completed.
  assign w_cnt_last   = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  dmem_lane u_lane (
    .i_size      (w_size),
    .i_addr_lo   (w_addr_lo),
    .i_wr_data   (io_bus.wr_data),
    .i_bus_rdata (io_bus.bus_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rd_data   (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= SizeByte;
      r_addr_lo   <= 2'b00;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rd_data   <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
          if (io_bus.mreq) begin
            if (w_misaligned) begin
              r_misalign <= 1'b1;
              r_rd_data  <= '0;
              r_state    <= StDone;
            end else begin
              r_we        <= io_bus.write;
              r_size      <= norm_size(io_bus.access_size);
              r_addr_lo   <= io_bus.addr[1:0];
              r_bus_addr  <= {io_bus.addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_state     <= StReq;
            end
          end
        end
        StReq: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (io_bus.bus_ack) begin
            r_bus_req <= 1'b0;
            r_rd_data <= r_we ? 32'h0 : w_rdata;
            r_state   <= StDone;
          end else if (w_cnt_last) begin
            r_bus_req <= 1'b0;
            r_rd_data <= '0;
            r_bus_err <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.stall     = ((r_state == StIdle) && io_bus.mreq) || (r_state == StReq);
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.misalign  = r_misalign;
  assign io_bus.bus_err   = r_bus_err;
  assign io_bus.bus_req   = r_bus_req;
  assign io_bus.bus_we    = r_we;
  assign io_bus.bus_addr  = r_bus_addr;
  assign io_bus.bus_be    = r_bus_be;
  assign io_bus.bus_wdata = r_bus_wdata;

endmodule
